// File: rtl/mul_mod_arb.sv
// Two-requester round-robin arbiter that time-shares one y*z mod n multiplier.
// Aborts a hung operation after TIMEOUT cycles in WAIT and reports it through err.
module mul_mod_arb #(
  parameter int W       = 256,
  parameter int TIMEOUT = 512
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] y0,
  input  logic [W-1:0] z0,
  input  logic [W-1:0] n0,
  input  logic [W-1:0] y1,
  input  logic [W-1:0] z1,
  input  logic [W-1:0] n1,
  output logic         ack0,
  output logic         ack1,
  output logic [W-1:0] res,
  output logic [1:0]   done,
  output logic         err,
  output logic         busy,
  output logic [W-1:0] mm_y,
  output logic [W-1:0] mm_z,
  output logic [W-1:0] mm_n,
  output logic         mm_ready,
  output logic         mm_reset,
  input  logic [W-1:0] mm_M,
  input  logic         mm_valid
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state_q;
  logic            owner_q;
  logic            last_owner_q;
  logic            err_flag_q;
  logic [CW-1:0]   cnt_q;
  logic            ack0_q;
  logic            ack1_q;
  logic [W-1:0]    res_q;
  logic [1:0]      done_q;
  logic            err_q;
  logic            busy_q;
  logic [W-1:0]    mm_y_q;
  logic [W-1:0]    mm_z_q;
  logic [W-1:0]    mm_n_q;
  logic            mm_ready_q;
  logic            abort_q;
  logic            grant1_d;

  // On a tie the requester that did not own the multiplier last time wins.
  always_comb begin
    grant1_d = req1 && (!req0 || !last_owner_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      err_flag_q   <= 1'b0;
      cnt_q        <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      res_q        <= '0;
      done_q       <= 2'b00;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      mm_y_q       <= '0;
      mm_z_q       <= '0;
      mm_n_q       <= '0;
      mm_ready_q   <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      done_q     <= 2'b00;
      err_q      <= 1'b0;
      mm_ready_q <= 1'b0;
      abort_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            if (grant1_d) begin
              mm_y_q  <= y1;
              mm_z_q  <= z1;
              mm_n_q  <= n1;
              owner_q <= 1'b1;
              ack1_q  <= 1'b1;
            end else begin
              mm_y_q  <= y0;
              mm_z_q  <= z0;
              mm_n_q  <= n0;
              owner_q <= 1'b0;
              ack0_q  <= 1'b1;
            end
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          mm_ready_q <= 1'b1;
          cnt_q      <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          // A completion in the final allowed cycle still counts as success.
          if (mm_valid) begin
            res_q      <= mm_M;
            err_flag_q <= 1'b0;
            state_q    <= DONE;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            abort_q    <= 1'b1;
            res_q      <= '0;
            err_flag_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          done_q       <= {owner_q, ~owner_q};
          err_q        <= err_flag_q;
          last_owner_q <= owner_q;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign res      = res_q;
  assign done     = done_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign mm_y     = mm_y_q;
  assign mm_z     = mm_z_q;
  assign mm_n     = mm_n_q;
  assign mm_ready = mm_ready_q;
  assign mm_reset = reset | abort_q;

endmodule

// File: tb/tb_mul_mod_arb.sv
// Directed bench for mul_mod_arb with a stub multiplier of programmable latency.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_mul_mod_arb;
  localparam int W  = 16;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] y0 = '0, z0 = '0, n0 = '0, y1 = '0, z1 = '0, n1 = '0;
  logic         ack0, ack1, err, busy, mm_ready, mm_reset, mm_valid;
  logic [W-1:0] res, mm_y, mm_z, mm_n, mm_M;
  logic [1:0]   done;

  int           total = 0;
  int           bad = 0;

  int           lat = 2;
  bit           stubEnable = 1'b1;
  logic         stubValid = 1'b0;
  logic         spurValid = 1'b0;
  logic [W-1:0] stubM = '0;
  logic         stubBusy = 1'b0;
  int           left = 0;

  typedef struct {
    int           sel;
    logic [W-1:0] y;
    logic [W-1:0] z;
    logic [W-1:0] n;
    logic [W-1:0] expRes;
  } vec_t;
  vec_t vecs[8];

  mul_mod_arb #(.W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .y0(y0), .z0(z0), .n0(n0), .y1(y1), .z1(z1), .n1(n1),
    .ack0(ack0), .ack1(ack1), .res(res), .done(done), .err(err), .busy(busy),
    .mm_y(mm_y), .mm_z(mm_z), .mm_n(mm_n), .mm_ready(mm_ready), .mm_reset(mm_reset),
    .mm_M(mm_M), .mm_valid(mm_valid)
  );

  always #5 clk = ~clk;

  assign mm_valid = stubValid | spurValid;
  assign mm_M     = stubM;

  // Stub multiplier: result appears lat+1 cycles after it samples the start pulse.
  always @(posedge clk) begin
    stubValid <= 1'b0;
    if (mm_reset) begin
      stubBusy <= 1'b0;
    end else if (mm_ready) begin
      stubBusy <= 1'b1;
      left     <= lat;
      stubM    <= W'((longint'(mm_y) * longint'(mm_z)) % longint'(mm_n));
    end else if (stubBusy) begin
      if (left == 0) begin
        stubValid <= stubEnable;
        stubBusy  <= 1'b0;
      end else begin
        left <= left - 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic waitAck(input int sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if ((sel == 0 && ack0) || (sel == 1 && ack1)) ok = 1'b1;
    end
  endtask

  task automatic waitDone(output logic [1:0] d, output int cyc, output int rstSeen);
    d = 2'b00;
    cyc = 0;
    rstSeen = 0;
    for (int i = 0; i < TO + 60 && d == 2'b00; i++) begin
      @(negedge clk);
      cyc++;
      if (mm_reset) rstSeen++;
      if (done != 2'b00) d = done;
    end
  endtask

  task automatic applyStimulus(input int sel, input logic [W-1:0] y, input logic [W-1:0] z,
                               input logic [W-1:0] n, input logic [W-1:0] expRes);
    bit ok;
    logic [1:0] d;
    int cyc, rs;
    @(negedge clk);
    if (sel == 0) begin req0 = 1'b1; y0 = y; z0 = z; n0 = n; end
    else          begin req1 = 1'b1; y1 = y; z1 = z; n1 = n; end
    waitAck(sel, ok);
    checkOutput("ack seen", ok, 1);
    checkOutput("other ack", (sel == 0) ? ack1 : ack0, 0);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    checkOutput("mm_ready after ack", mm_ready, 1);
    waitDone(d, cyc, rs);
    checkOutput("done bit", d, (sel == 0) ? 2'b01 : 2'b10);
    checkOutput("err clear", err, 0);
    checkOutput("res value", res, expRes);
    checkOutput("operands held", mm_y, y);
  endtask

  initial begin
    bit ok;
    logic [1:0] d;
    int cyc, rs, nAck, early, dn;
    int order[4];
    logic [W-1:0] r;

    vecs[0] = '{0, 16'd3,    16'd5,    16'd7,    16'd1};
    vecs[1] = '{1, 16'd10,   16'd10,   16'd7,    16'd2};
    vecs[2] = '{0, 16'd123,  16'd45,   16'd1000, 16'd535};
    vecs[3] = '{1, 16'd255,  16'd255,  16'd256,  16'd1};
    vecs[4] = '{0, 16'd0,    16'd9,    16'd11,   16'd0};
    vecs[5] = '{1, 16'd1000, 16'd1000, 16'd997,  16'd9};
    vecs[6] = '{1, 16'd6,    16'd7,    16'd5,    16'd2};
    vecs[7] = '{0, 16'd1,    16'd1,    16'd2,    16'd1};

    // Reset values while reset is still asserted.
    repeat (3) @(negedge clk);
    checkOutput("reset mm_reset", mm_reset, 1);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset ack", {ack0, ack1}, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset err", err, 0);
    checkOutput("reset res", res, 0);
    checkOutput("reset mm_y", mm_y, 0);
    checkOutput("reset mm_ready", mm_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mm_reset released", mm_reset, 0);

    // Tie straight after reset: requester 0 first, then 1 with no gap.
    req0 = 1'b1; y0 = 16'd3; z0 = 16'd5; n0 = 16'd7;
    req1 = 1'b1; y1 = 16'd6; z1 = 16'd7; n1 = 16'd5;
    waitAck(0, ok);
    checkOutput("tie ack0", ok, 1);
    checkOutput("tie ack1 low", ack1, 0);
    checkOutput("tie busy", busy, 1);
    req0 = 1'b0;
    @(negedge clk);
    checkOutput("tie mm_y latched", mm_y, 16'd3);
    waitDone(d, cyc, rs);
    checkOutput("tie done0", d, 2'b01);
    checkOutput("tie res0", res, 16'd1);
    @(negedge clk);
    checkOutput("tie ack1 back-to-back", ack1, 1);
    req1 = 1'b0;
    waitDone(d, cyc, rs);
    checkOutput("tie done1", d, 2'b10);
    checkOutput("tie res1", res, 16'd2);

    // Fairness with both requests held.
    for (int k = 0; k < 4; k++) order[k] = -1;
    nAck = 0;
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 200 && nAck < 4; i++) begin
      @(negedge clk);
      if (ack0) begin order[nAck] = 0; nAck++; end
      else if (ack1) begin order[nAck] = 1; nAck++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int k = 0; k < 4; k++) checkOutput($sformatf("fair grant %0d", k), order[k], k % 2);
    waitDone(d, cyc, rs);
    checkOutput("fair last done", d, 2'b10);

    for (int v = 0; v < 8; v++)
      applyStimulus(vecs[v].sel, vecs[v].y, vecs[v].z, vecs[v].n, vecs[v].expRes);

    // Multiplier never answers: abort after TO WAIT cycles.
    stubEnable = 1'b0;
    @(negedge clk);
    req0 = 1'b1; y0 = 16'd3; z0 = 16'd5; n0 = 16'd7;
    waitAck(0, ok);
    checkOutput("timeout ack", ok, 1);
    req0 = 1'b0;
    waitDone(d, cyc, rs);
    checkOutput("timeout done", d, 2'b01);
    checkOutput("timeout err", err, 1);
    checkOutput("timeout res", res, 0);
    checkOutput("timeout mm_reset pulses", rs, 1);
    checkOutput("timeout latency", cyc, TO + 2);
    stubEnable = 1'b1;
    applyStimulus(1, 16'd10, 16'd10, 16'd7, 16'd2);

    // Completion in the last allowed WAIT cycle wins over the abort.
    lat = 13;
    @(negedge clk);
    req0 = 1'b1; y0 = 16'd123; z0 = 16'd45; n0 = 16'd1000;
    waitAck(0, ok);
    checkOutput("edge ack", ok, 1);
    req0 = 1'b0;
    waitDone(d, cyc, rs);
    checkOutput("edge done", d, 2'b01);
    checkOutput("edge err", err, 0);
    checkOutput("edge res", res, 16'd535);
    checkOutput("edge no abort", rs, 0);
    checkOutput("edge latency", cyc, TO + 2);
    lat = 2;

    // Reset during WAIT.
    stubEnable = 1'b0;
    @(negedge clk);
    req0 = 1'b1; y0 = 16'd3; z0 = 16'd5; n0 = 16'd7;
    waitAck(0, ok);
    checkOutput("rst ack", ok, 1);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst busy before", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst busy in reset", busy, 0);
    checkOutput("rst mm_reset", mm_reset, 1);
    @(negedge clk);
    reset = 1'b0;
    stubEnable = 1'b1;
    dn = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done != 2'b00) dn++;
    end
    checkOutput("rst no done", dn, 0);
    checkOutput("rst idle", busy, 0);

    // Spurious mm_valid in IDLE, then a request raised while busy.
    applyStimulus(0, 16'd10, 16'd10, 16'd7, 16'd2);
    r = res;
    @(negedge clk);
    spurValid = 1'b1;
    @(negedge clk);
    spurValid = 1'b0;
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done != 2'b00) dn++;
    end
    checkOutput("spur no done", dn, 0);
    checkOutput("spur res kept", res, r);
    checkOutput("spur idle", busy, 0);

    lat = 6;
    @(negedge clk);
    req0 = 1'b1; y0 = 16'd3; z0 = 16'd5; n0 = 16'd7;
    waitAck(0, ok);
    checkOutput("busy-req ack0", ok, 1);
    req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    req1 = 1'b1; y1 = 16'd6; z1 = 16'd7; n1 = 16'd5;
    early = 0;
    d = 2'b00;
    for (int i = 0; i < TO + 60 && d == 2'b00; i++) begin
      @(negedge clk);
      if (ack1) early++;
      if (done != 2'b00) d = done;
    end
    checkOutput("busy-req no early ack1", early, 0);
    checkOutput("busy-req done0", d, 2'b01);
    checkOutput("busy-req res0", res, 16'd1);
    @(negedge clk);
    checkOutput("busy-req ack1 after done", ack1, 1);
    req1 = 1'b0;
    waitDone(d, cyc, rs);
    checkOutput("busy-req done1", d, 2'b10);
    checkOutput("busy-req res1", res, 16'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
